// File: rtl/ctrl_regs_mch.sv
// Multi-channel control/status register block: per-channel CTRL/MARGIN/FLAG/WMARK,
// a global ID word, sticky watermark flags and a registered level interrupt.
module ctrl_regs_mch #(
    parameter int NUM_CH            = 3,
    parameter int ADDR_WIDTH        = 8,
    parameter int CMD_DATA_WIDTH    = 32,
    parameter int FIFO_MARGIN_WIDTH = 8,
    parameter int FIFO_DEPTH        = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [1:0]                            cmd_i,
    input  logic [ADDR_WIDTH-1:0]                 cmd_addr_i,
    input  logic [CMD_DATA_WIDTH-1:0]             cmd_data_i,
    output logic [CMD_DATA_WIDTH-1:0]             cmd_data_o,
    output logic                                  cmd_vld_o,
    output logic                                  cmd_err_o,
    input  logic [NUM_CH*FIFO_MARGIN_WIDTH-1:0]   margin_i,
    output logic [NUM_CH-1:0]                     en_o,
    output logic [NUM_CH*2-1:0]                   prio_o,
    output logic [NUM_CH*3-1:0]                   pkglen_o,
    output logic                                  irq_o
);
    localparam int W  = FIFO_MARGIN_WIDTH;
    localparam int DW = CMD_DATA_WIDTH;
    localparam int CW = ADDR_WIDTH - 4;
    localparam logic [CW-1:0]         NUM_CH_C = CW'(NUM_CH);
    localparam logic [ADDR_WIDTH-1:0] ID_ADDR  = ADDR_WIDTH'(8'hF0);
    localparam logic [7:0]            NUM_CH_B = 8'(NUM_CH);
    localparam logic [31:0]           ID_VAL   = {16'h0, NUM_CH_B, 8'h02};

    logic [CW-1:0]      ch_idx;
    logic [1:0]         reg_off;
    logic               is_rd, is_wr, aligned, is_id, ch_hit, rd_ok, wr_ok;
    logic [DW-1:0]      cmd_data_d, cmd_data_q;
    logic               cmd_vld_q, cmd_err_d, cmd_err_q;
    logic               irq_d, irq_q;
    logic [NUM_CH-1:0]  irq_terms;
    logic [NUM_CH*DW-1:0] ch_rd_flat;
    logic               unused_data;

    assign ch_idx  = cmd_addr_i[ADDR_WIDTH-1:4];
    assign reg_off = cmd_addr_i[3:2];
    assign is_rd   = (cmd_i == 2'b01);
    assign is_wr   = (cmd_i == 2'b10);
    assign aligned = (cmd_addr_i[1:0] == 2'b00);
    assign is_id   = (cmd_addr_i == ID_ADDR);
    assign ch_hit  = aligned && (ch_idx < NUM_CH_C);
    assign rd_ok   = ch_hit || is_id;
    // MARGIN is the only read-only slot inside a channel window.
    assign wr_ok   = ch_hit && (reg_off != 2'd1);
    assign cmd_err_d = (is_rd && !rd_ok) || (is_wr && !wr_ok);
    assign unused_data = ^cmd_data_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [7:0]    ctrl_q;
            logic [W-1:0]  margin_q, wmark_q;
            logic [1:0]    flag_q, flag_d, flag_set, flag_clr;
            logic          sel;
            logic [DW-1:0] rd_val;

            assign sel      = is_wr && wr_ok && (ch_idx == CW'(gi));
            assign flag_set = {margin_q == '0, margin_q < wmark_q};
            assign flag_clr = (sel && reg_off == 2'd2) ? cmd_data_i[1:0] : 2'b00;
            // Clear is applied first so a coincident set condition keeps the bit.
            assign flag_d   = (flag_q & ~flag_clr) | flag_set;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ctrl_q   <= 8'h07;
                    margin_q <= W'(FIFO_DEPTH);
                    wmark_q  <= W'(4);
                    flag_q   <= 2'b00;
                end else begin
                    margin_q <= margin_i[gi*W +: W];
                    flag_q   <= flag_d;
                    if (sel && reg_off == 2'd0) ctrl_q  <= cmd_data_i[7:0];
                    if (sel && reg_off == 2'd3) wmark_q <= cmd_data_i[W-1:0];
                end
            end

            always_comb begin
                rd_val = '0;
                case (reg_off)
                    2'd0:    rd_val = DW'(ctrl_q);
                    2'd1:    rd_val = DW'(margin_q);
                    2'd2:    rd_val = DW'(flag_q);
                    default: rd_val = DW'(wmark_q);
                endcase
            end

            assign ch_rd_flat[gi*DW +: DW] = rd_val;
            assign irq_terms[gi]           = |(flag_q & ctrl_q[7:6]);
            assign en_o[gi]                = ctrl_q[0];
            assign prio_o[gi*2 +: 2]       = ctrl_q[2:1];
            assign pkglen_o[gi*3 +: 3]     = ctrl_q[5:3];
        end
    endgenerate

    always_comb begin
        cmd_data_d = '0;
        if (is_id) begin
            cmd_data_d = DW'(ID_VAL);
        end else if (ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == CW'(c)) cmd_data_d = ch_rd_flat[c*DW +: DW];
            end
        end
    end

    assign irq_d = |irq_terms;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_data_q <= '0;
            cmd_vld_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            cmd_vld_q <= is_rd;
            cmd_err_q <= cmd_err_d;
            irq_q     <= irq_d;
            if (is_rd) cmd_data_q <= cmd_data_d;
        end
    end

    assign cmd_data_o = cmd_data_q;
    assign cmd_vld_o  = cmd_vld_q;
    assign cmd_err_o  = cmd_err_q;
    assign irq_o      = irq_q;
endmodule

// File: doc/ctrl_regs_mch.md
CTRL_REGS_MCH -- requirements
Module: ctrl_regs_mch

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, command address width.
REQ-003 SHALL have parameter CMD_DATA_WIDTH, default 32, command data width (legal >= 16).
REQ-004 SHALL have parameter FIFO_MARGIN_WIDTH, default 8, per-channel margin width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, reset value of every margin register.
REQ-006 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port cmd_i  in  2  command: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 idle.
REQ-009 SHALL have port cmd_addr_i  in  ADDR_WIDTH  register byte address.
REQ-010 SHALL have port cmd_data_i  in  CMD_DATA_WIDTH  write data.
REQ-011 SHALL have port cmd_data_o  out  CMD_DATA_WIDTH  read data, registered.
REQ-012 SHALL have port cmd_vld_o  out  1  one-cycle pulse, read data valid.
REQ-013 SHALL have port cmd_err_o  out  1  one-cycle pulse, illegal access.
REQ-014 SHALL have port margin_i  in  NUM_CH*FIFO_MARGIN_WIDTH  channel c at slice [c*W+:W].
REQ-015 SHALL have ports en_o (NUM_CH), prio_o (NUM_CH*2), pkglen_o (NUM_CH*3), all outputs, channel c at slice c.
REQ-016 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-017 Address map per channel c, base c*16: +0 CTRL (RW), +4 MARGIN (RO), +8 FLAG (W1C), +12 WMARK (RW); 0xF0 ID (RO, value {16'h0, NUM_CH[7:0], 8'h02}).
REQ-018 CTRL layout: [0] en, [2:1] prio, [5:3] pkglen, [7:6] irq_en (bit6 LOW, bit7 FULL); bits above 7 reserved, read 0, writes ignored.
REQ-019 WMARK layout: [FIFO_MARGIN_WIDTH-1:0] threshold; upper bits reserved, read 0.
REQ-020 Write: cmd_i==write to CTRL/WMARK updates the register at the next edge, visible on en_o/prio_o/pkglen_o at that edge.
REQ-021 Read: cmd_i==read registers the addressed value into cmd_data_o and pulses cmd_vld_o exactly one cycle later; cmd_data_o holds otherwise.
REQ-022 Read and write are pipelined back-to-back with no wait state; a read of a register written the previous cycle returns the new value.
REQ-023 MARGIN[c] SHALL register margin_i slice c every cycle, zero-extended; reads return the registered value.
REQ-024 FLAG bit0 LOW SHALL set when registered MARGIN[c] < WMARK[c]; bit1 FULL SHALL set when registered MARGIN[c] == 0; both sticky.
REQ-025 FLAG bits SHALL clear only by writing 1 to them; set condition in the same cycle as a clear SHALL win (bit stays 1).
REQ-026 irq_o SHALL equal OR over c of (FLAG[c][1:0] & CTRL[c][7:6]), registered, one cycle after the flag/enable change.
REQ-027 Illegal access (address beyond channel NUM_CH-1 and not ID, unaligned address, write to MARGIN or ID) SHALL pulse cmd_err_o one cycle later, change no state; an illegal read also returns 0 with cmd_vld_o pulsed.
REQ-028 Idle commands SHALL leave cmd_vld_o and cmd_err_o low.

Reset
REQ-029 While rst_i is high: CTRL=0x07 (en=1, prio=3, pkglen=0, irq_en=0), MARGIN=FIFO_DEPTH, WMARK=4, FLAG=0, cmd_data_o=0, cmd_vld_o=0, cmd_err_o=0, irq_o=0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight read (no cmd_vld_o after release); first command accepted on the first rising edge with rst_i low.

Verification
REQ-031 Reset then read 0x00, 0x04, 0xF0 -> 0x07, 0x20, 0x00000302, each one cycle after command with cmd_vld_o pulse.
REQ-032 Write 0x1C to 0x10 with 0xFFFFFFFF -> CTRL[1] reads 0x000000FF, en_o[1]=1, prio_o[3:2]=3, pkglen_o[5:3]=7; channel 0/2 unchanged.
REQ-033 Write CTRL[2]=0x41, WMARK[2]=8, drive margin_i ch2=5 -> FLAG[2]=0x1 two cycles later, irq_o=1 one cycle after; margin back to 32 keeps FLAG=0x1; write 0x1 to 0x28 -> FLAG=0, irq_o=0.
REQ-034 Hold margin_i ch0=0 while writing 0x3 to 0x08 -> FLAG[0] stays 0x3 (set wins).
REQ-035 Write to 0x04, read 0x30 (NUM_CH=3), read 0x02 -> cmd_err_o pulse each, reads return 0, no register changes.
REQ-036 Issue read, assert rst_i for one cycle before the response edge -> no cmd_vld_o, all registers at REQ-029 values.
